// File: rtl/mem_arbiter_if.sv
// Bus bundle between two masters, the arbiter and one 36-bit memory slave.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
    logic [17:0] m0_address;
    logic [17:0] m1_address;
    logic        m0_read;
    logic        m0_write;
    logic        m1_read;
    logic        m1_write;
    logic [35:0] m0_writedata;
    logic [35:0] m1_writedata;
    logic [35:0] m0_readdata;
    logic [35:0] m1_readdata;
    logic        m0_waitrequest;
    logic        m1_waitrequest;
    logic [17:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [35:0] s_writedata;
    logic [35:0] s_readdata;
    logic        s_waitrequest;
    logic        nxm;
    logic        nxm_master;

    modport slave (
        input  m0_address, m1_address,
        input  m0_read, m0_write, m1_read, m1_write,
        input  m0_writedata, m1_writedata,
        output m0_readdata, m1_readdata,
        output m0_waitrequest, m1_waitrequest,
        output s_address, s_read, s_write, s_writedata,
        input  s_readdata, s_waitrequest,
        output nxm, nxm_master
    );

    modport master (
        output m0_address, m1_address,
        output m0_read, m0_write, m1_read, m1_write,
        output m0_writedata, m1_writedata,
        input  m0_readdata, m1_readdata,
        input  m0_waitrequest, m1_waitrequest,
        input  s_address, s_read, s_write, s_writedata,
        output s_readdata, s_waitrequest,
        input  nxm, nxm_master
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a 36-bit memory slave,
// with a stall timeout that aborts a hung transaction as non-existent memory.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic       clk,
    input logic       reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1
    } state_t;

    localparam logic [9:0] LIMIT = 10'(TIMEOUT - 1);

    state_t      state;
    logic        last;
    logic [9:0]  cnt;
    logic        nxm_q;
    logic        nxm_m_q;

    logic        req0;
    logic        req1;
    logic        gnt0;
    logic        gnt1;
    logic        cur_req;
    logic        cur_rd;
    logic        cur_wr;
    logic [17:0] cur_addr;
    logic [35:0] cur_wdata;
    logic        tmo;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;
    assign gnt0 = (state == BUSY0);
    assign gnt1 = (state == BUSY1);

    // read+write together is a write
    always_comb begin
        cur_req   = 1'b0;
        cur_rd    = 1'b0;
        cur_wr    = 1'b0;
        cur_addr  = '0;
        cur_wdata = '0;
        case (state)
            BUSY0: begin
                cur_req   = req0;
                cur_rd    = bus.m0_read & ~bus.m0_write;
                cur_wr    = bus.m0_write;
                cur_addr  = bus.m0_address;
                cur_wdata = bus.m0_writedata;
            end
            BUSY1: begin
                cur_req   = req1;
                cur_rd    = bus.m1_read & ~bus.m1_write;
                cur_wr    = bus.m1_write;
                cur_addr  = bus.m1_address;
                cur_wdata = bus.m1_writedata;
            end
            default: begin
                cur_req = 1'b0;
            end
        endcase
    end

    assign tmo = (gnt0 | gnt1) & cur_req & bus.s_waitrequest
               & (cnt == LIMIT);

    assign bus.s_address   = cur_addr;
    assign bus.s_read      = cur_rd & ~tmo;
    assign bus.s_write     = cur_wr & ~tmo;
    assign bus.s_writedata = cur_wdata;

    assign bus.m0_waitrequest = gnt0 ? (bus.s_waitrequest & ~tmo) : 1'b1;
    assign bus.m1_waitrequest = gnt1 ? (bus.s_waitrequest & ~tmo) : 1'b1;

    assign bus.m0_readdata = (gnt0 & tmo) ? '0 : bus.s_readdata;
    assign bus.m1_readdata = (gnt1 & tmo) ? '0 : bus.s_readdata;

    assign bus.nxm        = nxm_q;
    assign bus.nxm_master = nxm_m_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            cnt     <= '0;
            nxm_q   <= 1'b0;
            nxm_m_q <= 1'b0;
        end else begin
            nxm_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req0 && (!req1 || last)) begin
                        state <= BUSY0;
                    end else if (req1) begin
                        state <= BUSY1;
                    end
                end
                default: begin
                    if (!cur_req) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!bus.s_waitrequest || tmo) begin
                        // completion wins over a coincident timeout
                        state <= IDLE;
                        last  <= gnt1;
                        cnt   <= '0;
                        if (bus.s_waitrequest) begin
                            nxm_q   <= 1'b1;
                            nxm_m_q <= gnt1;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // model: who owns the slave, who won last, how long it has stalled
    int owner = -1;
    int lastw = 1;
    int stall = 0;
    bit m_nxm = 0;
    bit m_nxm_m = 0;
    bit done[2];
    bit chk_en = 0;

    function automatic bit rq(int i);
        return i == 0 ? (bus.m0_read | bus.m0_write)
                      : (bus.m1_read | bus.m1_write);
    endfunction

    function automatic bit wr(int i);
        return i == 0 ? bus.m0_write : bus.m1_write;
    endfunction

    function automatic bit rd(int i);
        return i == 0 ? bus.m0_read : bus.m1_read;
    endfunction

    function automatic logic [17:0] addr(int i);
        return i == 0 ? bus.m0_address : bus.m1_address;
    endfunction

    function automatic logic [35:0] wdat(int i);
        return i == 0 ? bus.m0_writedata : bus.m1_writedata;
    endfunction

    function automatic bit timing_out();
        if (owner < 0) return 1'b0;
        return rq(owner) && bus.s_waitrequest && (stall == T - 1);
    endfunction

    always @(posedge clk or negedge reset) begin : model_upd
        bit t;
        if (!reset) begin
            owner = -1;
            lastw = 1;
            stall = 0;
            m_nxm = 0;
            m_nxm_m = 0;
            done[0] = 0;
            done[1] = 0;
        end else begin
            t = timing_out();
            m_nxm = 0;
            done[0] = 0;
            done[1] = 0;
            if (owner < 0) begin
                stall = 0;
                if (rq(0) && rq(1)) owner = 1 - lastw;
                else if (rq(0)) owner = 0;
                else if (rq(1)) owner = 1;
            end else if (!rq(owner)) begin
                owner = -1;
            end else if (!bus.s_waitrequest || t) begin
                done[owner] = 1;
                lastw = owner;
                if (t && bus.s_waitrequest) begin
                    m_nxm = 1;
                    m_nxm_m = owner[0];
                end
                owner = -1;
            end else begin
                stall++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit t;
        logic [17:0] ea;
        logic [35:0] ed, r0, r1;
        bit er, ew, w0, w1;
        if (chk_en) begin
            t = timing_out();
            ea = '0; ed = '0; er = 0; ew = 0; w0 = 1; w1 = 1;
            r0 = bus.s_readdata;
            r1 = bus.s_readdata;
            if (owner >= 0) begin
                ea = addr(owner);
                ed = wdat(owner);
                ew = wr(owner) && !t;
                er = rd(owner) && !wr(owner) && !t;
                if (owner == 0) begin
                    w0 = t ? 1'b0 : bus.s_waitrequest;
                    if (t) r0 = '0;
                end else begin
                    w1 = t ? 1'b0 : bus.s_waitrequest;
                    if (t) r1 = '0;
                end
            end
            check("s_address", bus.s_address, ea);
            check("s_read", bus.s_read, er);
            check("s_write", bus.s_write, ew);
            check("s_writedata", bus.s_writedata, ed);
            check("m0_waitrequest", bus.m0_waitrequest, w0);
            check("m1_waitrequest", bus.m1_waitrequest, w1);
            check("m0_readdata", bus.m0_readdata, r0);
            check("m1_readdata", bus.m1_readdata, r1);
            check("nxm", bus.nxm, m_nxm);
            check("nxm_master", bus.nxm_master, m_nxm_m);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, bit r, bit w);
        logic [17:0] a;
        logic [35:0] d;
        a = 18'($urandom);
        d = 36'({$urandom, $urandom});
        if (i == 0) begin
            bus.m0_address = a;
            bus.m0_writedata = d;
            bus.m0_read = r;
            bus.m0_write = w;
        end else begin
            bus.m1_address = a;
            bus.m1_writedata = d;
            bus.m1_read = r;
            bus.m1_write = w;
        end
    endtask

    int grants[$];

    initial begin
        bus.m0_address = '0;
        bus.m1_address = '0;
        bus.m0_read = 0;
        bus.m0_write = 0;
        bus.m1_read = 0;
        bus.m1_write = 0;
        bus.m0_writedata = '0;
        bus.m1_writedata = '0;
        bus.s_readdata = '0;
        bus.s_waitrequest = 0;

        #3;
        check("rst s_read", bus.s_read, 0);
        check("rst s_write", bus.s_write, 0);
        check("rst m0_wait", bus.m0_waitrequest, 1);
        check("rst m1_wait", bus.m1_waitrequest, 1);
        check("rst nxm", bus.nxm, 0);
        check("rst nxm_master", bus.nxm_master, 0);
        chk_en = 1;
        #4 reset = 1;

        // single read
        bus.m0_read = 1;
        bus.m0_address = 18'o000100;
        bus.s_readdata = 36'h987654321;
        tick();
        check("rd s_read", bus.s_read, 1);
        check("rd s_address", bus.s_address, 18'o000100);
        check("rd m0_wait", bus.m0_waitrequest, 0);
        check("rd m0_readdata", bus.m0_readdata, 36'h987654321);
        check("rd m1_wait", bus.m1_waitrequest, 1);
        tick();
        bus.m0_read = 0;
        check("rd idle s_read", bus.s_read, 0);
        check("rd idle m0_wait", bus.m0_waitrequest, 1);

        // tie after reset: m0 first
        reset = 0;
        #1 reset = 1;
        bus.m0_write = 1;
        bus.m0_writedata = 36'ha5a5a5a5a;
        bus.m1_read = 1;
        bus.m1_address = 18'o777;
        tick();
        check("tie s_write", bus.s_write, 1);
        check("tie s_writedata", bus.s_writedata, 36'ha5a5a5a5a);
        check("tie m0_wait", bus.m0_waitrequest, 0);
        check("tie m1_wait", bus.m1_waitrequest, 1);
        tick();
        bus.m0_write = 0;
        check("tie gap m1_wait", bus.m1_waitrequest, 1);
        tick();
        check("tie m1 grant", bus.m1_waitrequest, 0);
        check("tie m1 s_addr", bus.s_address, 18'o777);
        tick();
        bus.m1_read = 0;
        bus.m0_read = 1;
        tick();
        tick();
        bus.m0_read = 0;
        // last is now 0: m1 wins the next tie
        bus.m0_read = 1;
        bus.m1_read = 1;
        tick();
        check("tie2 m1_wait", bus.m1_waitrequest, 0);
        check("tie2 m0_wait", bus.m0_waitrequest, 1);
        tick();
        bus.m1_read = 0;
        tick();
        check("tie2 m0 grant", bus.m0_waitrequest, 0);
        tick();
        bus.m0_read = 0;

        // continuous contention
        bus.m0_read = 1;
        bus.m1_read = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.m0_waitrequest === 1'b0) grants.push_back(0);
            if (bus.m1_waitrequest === 1'b0) grants.push_back(1);
        end
        bus.m0_read = 0;
        bus.m1_read = 0;
        check("alt count", grants.size(), 20);
        if (grants.size() > 0) check("alt first", grants[0], 1);
        for (int k = 1; k < grants.size(); k++)
            check("alt order", grants[k], 1 - grants[k-1]);

        // timeout on m1
        bus.s_waitrequest = 1;
        bus.s_readdata = 36'hfff0000f;
        bus.m1_read = 1;
        tick();
        check("to c1 m1_wait", bus.m1_waitrequest, 1);
        tick();
        tick();
        check("to c3 m1_wait", bus.m1_waitrequest, 1);
        check("to c3 nxm", bus.nxm, 0);
        tick();
        check("to c4 m1_wait", bus.m1_waitrequest, 0);
        check("to c4 m1_readdata", bus.m1_readdata, 0);
        check("to c4 s_read", bus.s_read, 0);
        tick();
        bus.m1_read = 0;
        check("to nxm", bus.nxm, 1);
        check("to nxm_master", bus.nxm_master, 1);
        tick();
        check("to nxm drop", bus.nxm, 0);
        check("to nxm_master hold", bus.nxm_master, 1);

        // completion coincides with timeout
        bus.s_readdata = 36'h123456789;
        bus.m0_read = 1;
        tick();
        tick();
        tick();
        tick();
        bus.s_waitrequest = 0;
        #1;
        check("co m0_wait", bus.m0_waitrequest, 0);
        check("co m0_readdata", bus.m0_readdata, 36'h123456789);
        check("co s_read", bus.s_read, 1);
        tick();
        bus.m0_read = 0;
        check("co nxm", bus.nxm, 0);

        // reset mid-transaction
        bus.s_waitrequest = 1;
        bus.m0_read = 1;
        tick();
        tick();
        reset = 0;
        #1;
        check("mr s_read", bus.s_read, 0);
        check("mr m0_wait", bus.m0_waitrequest, 1);
        check("mr m1_wait", bus.m1_waitrequest, 1);
        check("mr nxm", bus.nxm, 0);
        reset = 1;
        bus.m0_read = 0;
        bus.m1_read = 1;
        bus.s_waitrequest = 0;
        tick();
        check("mr m1 grant", bus.m1_waitrequest, 0);
        check("mr m1 s_read", bus.s_read, 1);
        tick();
        bus.m1_read = 0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                int k;
                k = $urandom_range(2);
                if (!rq(i)) begin
                    if ($urandom_range(3) == 0) set_req(i, k != 1, k != 0);
                end else if (done[i]) begin
                    if ($urandom_range(1) == 1) set_req(i, k != 1, k != 0);
                    else set_req(i, 0, 0);
                end else if ($urandom_range(63) == 0) begin
                    set_req(i, 0, 0);
                end
            end
            if ((c % 500) < 100) bus.s_waitrequest = ($urandom_range(15) != 0);
            else bus.s_waitrequest = ($urandom_range(2) == 0);
            bus.s_readdata = 36'({$urandom, $urandom});
            if ($urandom_range(999) == 0) begin
                reset = 0;
                #1 reset = 1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
